// File: rtl/spram_bank_ctrl.sv
// Banked iCE40UP SPRAM controller: width-ganged, depth-stacked primitives with
// per-nibble write mask, one-cycle read latency and per-bank idle STANDBY.

// Behavioural stand-in for SB_SPRAM256KA (16K x 16, nibble MASKWREN, registered read port).
module spram_bank_ctrl_prim (
  input  logic        clk,
  input  logic [13:0] addr,
  input  logic [15:0] din,
  input  logic [3:0]  maskwren,
  input  logic        wren,
  input  logic        chipselect,
  input  logic        standby,
  input  logic        sleep,
  input  logic        poweroff,
  output logic [15:0] dout
);
  logic [15:0] mem_q [16384];
  logic [15:0] dout_q;
  logic        en;

  assign en   = chipselect && !standby && !sleep && poweroff;
  assign dout = dout_q;

  always_ff @(posedge clk) begin
    if (en && wren) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (maskwren[n]) mem_q[addr][4*n +: 4] <= din[4*n +: 4];
      end
    end
    if (en && !wren) dout_q <= mem_q[addr];
  end
endmodule

module spram_bank_ctrl #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int BANKS       = 2,
  parameter  int IDLE_LIMIT  = 1024,
  parameter  int WAKE_CYCLES = 3,
  localparam int ADDR_WIDTH  = 14 + $clog2(BANKS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH/4-1:0] cmd_mask,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  output logic                    rd_valid,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [BANKS-1:0]        bank_active
);
  localparam int PRIMS  = DATA_WIDTH / 16;
  localparam int IDLE_W = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;
  localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {S_ACTIVE, S_STANDBY, S_WAKING} bank_state_e;

  logic             bank_sel;
  logic             sel_active;
  logic             accept;
  logic [BANKS-1:0] standby_w;
  logic [BANKS-1:0] wren_w;
  logic [15:0]      dout_w [BANKS][PRIMS];
  logic             rd_valid_q;
  logic             rd_bank_q;

  always_comb begin
    bank_sel = (BANKS == 2) ? cmd_addr[ADDR_WIDTH-1] : 1'b0;
    sel_active = 1'b0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (bank_sel == 1'(b)) sel_active = bank_active[b];
    end
  end

  assign cmd_ready = !reset && sel_active;
  assign accept    = cmd_valid && cmd_ready;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    bank_state_e       state_q;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [WAKE_W-1:0] wake_q;
    logic              standby_q, active_q;
    logic              hit_b, acc_b;

    assign hit_b     = (bank_sel == 1'(b));
    assign acc_b     = accept && hit_b;
    assign wren_w[b] = acc_b && cmd_write;
    // Saturating increment; the transition compares the post-increment value so
    // STANDBY is visible IDLE_LIMIT+1 cycles after the last accept.
    assign idle_d    = (idle_q == IDLE_W'(IDLE_LIMIT)) ? idle_q : idle_q + IDLE_W'(1);

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q   <= S_ACTIVE;
        idle_q    <= '0;
        wake_q    <= '0;
        standby_q <= 1'b0;
        active_q  <= 1'b1;
      end else begin
        case (state_q)
          S_ACTIVE: begin
            if (acc_b) begin
              idle_q <= '0;
            end else if (IDLE_LIMIT != 0 && idle_d == IDLE_W'(IDLE_LIMIT)) begin
              idle_q    <= idle_d;
              state_q   <= S_STANDBY;
              standby_q <= 1'b1;
              active_q  <= 1'b0;
            end else begin
              idle_q <= idle_d;
            end
          end
          S_STANDBY: begin
            if (cmd_valid && hit_b) begin
              state_q   <= S_WAKING;
              wake_q    <= '0;
              standby_q <= 1'b0;
            end
          end
          S_WAKING: begin
            if (wake_q == WAKE_W'(WAKE_CYCLES - 1)) begin
              state_q  <= S_ACTIVE;
              idle_q   <= '0;
              active_q <= 1'b1;
            end else begin
              wake_q <= wake_q + WAKE_W'(1);
            end
          end
          default: state_q <= S_ACTIVE;
        endcase
      end
    end

    assign standby_w[b]   = standby_q;
    assign bank_active[b] = active_q;

    for (genvar p = 0; p < PRIMS; p++) begin : g_prim
      spram_bank_ctrl_prim u_prim (
        .clk        (clk),
        .addr       (cmd_addr[13:0]),
        .din        (cmd_data[16*p +: 16]),
        .maskwren   (cmd_mask[4*p +: 4]),
        .wren       (wren_w[b]),
        .chipselect (1'b1),
        .standby    (standby_w[b]),
        .sleep      (1'b0),
        .poweroff   (1'b1),
        .dout       (dout_w[b][p])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
    end else begin
      rd_valid_q <= accept && !cmd_write;
      if (accept) rd_bank_q <= bank_sel;
    end
  end

  assign rd_valid = rd_valid_q;

  always_comb begin
    rd_data = '0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if (rd_bank_q == 1'(b)) begin
        for (int unsigned p = 0; p < PRIMS; p++) rd_data[16*p +: 16] = dout_w[b][p];
      end
    end
  end
endmodule

// File: tb/tb_spram_bank_ctrl.sv
// Self-checking bench: directed vector table, hand sequences for standby/wake/reset,
// randomized traffic against a timestamp-based bank model, and a 16-bit no-standby instance.
module tb_spram_bank_ctrl;
  localparam int L = 8;
  localparam int W = 3;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, rd_valid;
  logic [14:0] cmd_addr;
  logic [7:0]  cmd_mask;
  logic [31:0] cmd_data, rd_data;
  logic [1:0]  bank_active;

  logic        c2_valid, c2_ready, c2_write, c2_rv;
  logic [13:0] c2_addr;
  logic [3:0]  c2_mask;
  logic [15:0] c2_data, c2_rd;
  logic [0:0]  c2_act;

  spram_bank_ctrl #(.DATA_WIDTH(32), .BANKS(2), .IDLE_LIMIT(L), .WAKE_CYCLES(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .bank_active(bank_active));

  spram_bank_ctrl #(.DATA_WIDTH(16), .BANKS(1), .IDLE_LIMIT(0), .WAKE_CYCLES(1)) dut16 (
    .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(c2_ready),
    .cmd_write(c2_write), .cmd_addr(c2_addr), .cmd_mask(c2_mask), .cmd_data(c2_data),
    .rd_valid(c2_rv), .rd_data(c2_rd), .bank_active(c2_act));

  int nchecks = 0;
  int nerrors = 0;

  // Reference model: a bank is awake while the cycle index is within L of its
  // last "touch" (accept, reset, or end of a wake-up), or once a wake-up finishes.
  int          t = 0;
  int          touch [2];
  bit          waking [2];
  int          wake_done [2];
  logic [31:0] mem_m [int];
  bit          pend_rv, pend_known;
  logic [31:0] pend_rd;

  logic        exp_ready, exp_rv, exp_known;
  logic [1:0]  exp_act;
  logic [31:0] exp_rd;
  logic        obs_ready, obs_rv;
  logic [1:0]  obs_act;
  logic [31:0] obs_rd;

  typedef struct {
    logic        v, w;
    logic [14:0] a;
    logic [7:0]  m;
    logic [31:0] d;
    logic        er, ev;
    logic [31:0] ed;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, t);
    end
  endtask

  function automatic bit m_active(input int b);
    if (waking[b]) return t >= wake_done[b];
    return t <= touch[b] + L;
  endfunction

  task automatic drive(input logic v, input logic w, input logic [14:0] a,
                       input logic [7:0] m, input logic [31:0] d);
    cmd_valid = v; cmd_write = w; cmd_addr = a; cmd_mask = m; cmd_data = d;
  endtask

  task automatic step();
    int b;
    bit acc;
    logic [31:0] word;
    @(negedge clk);
    for (int i = 0; i < 2; i++) if (waking[i] && t >= wake_done[i]) waking[i] = 0;
    exp_act   = {m_active(1), m_active(0)};
    b         = int'(cmd_addr[14]);
    exp_ready = !reset && exp_act[b];
    exp_rv    = pend_rv;
    exp_rd    = pend_rd;
    exp_known = pend_known;
    obs_ready = cmd_ready; obs_rv = rd_valid; obs_rd = rd_data; obs_act = bank_active;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin touch[i] = t; waking[i] = 0; end
      pend_rv = 0;
    end else begin
      acc     = cmd_valid && exp_ready;
      pend_rv = acc && !cmd_write;
      if (pend_rv) begin
        pend_known = mem_m.exists(int'(cmd_addr));
        pend_rd    = pend_known ? mem_m[int'(cmd_addr)] : 32'h0;
      end
      if (acc && cmd_write) begin
        word = mem_m.exists(int'(cmd_addr)) ? mem_m[int'(cmd_addr)] : 32'h0;
        for (int n = 0; n < 8; n++) if (cmd_mask[n]) word[4*n +: 4] = cmd_data[4*n +: 4];
        if (mem_m.exists(int'(cmd_addr)) || cmd_mask == 8'hFF) mem_m[int'(cmd_addr)] = word;
      end
      if (acc) touch[b] = t;
      else if (cmd_valid && !exp_act[b] && !waking[b]) begin
        waking[b] = 1; wake_done[b] = t + W + 1; touch[b] = t + W;
      end
    end
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, 32'(obs_ready), 32'(exp_ready));
    chk({tag, "_bank_active"}, 32'(obs_act), 32'(exp_act));
    chk({tag, "_rd_valid"}, 32'(obs_rv), 32'(exp_rv));
    if (exp_rv && exp_known) chk({tag, "_rd_data"}, obs_rd, exp_rd);
  endtask

  initial begin
    #1_000_000;
    nerrors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    int lowcnt, bad;
    bit hold;
    logic [14:0] a;

    tbl[0]  = '{1, 1, 15'h0005, 8'hFF, 32'hDEADBEEF, 1, 0, 32'h0};
    tbl[1]  = '{1, 0, 15'h0005, 8'h00, 32'h0,        1, 0, 32'h0};
    tbl[2]  = '{0, 0, 15'h0000, 8'h00, 32'h0,        1, 1, 32'hDEADBEEF};
    tbl[3]  = '{1, 1, 15'h0010, 8'hFF, 32'h11111111, 1, 0, 32'h0};
    tbl[4]  = '{1, 1, 15'h0010, 8'h0F, 32'hAAAAAAAA, 1, 0, 32'h0};
    tbl[5]  = '{1, 0, 15'h0010, 8'h00, 32'h0,        1, 0, 32'h0};
    tbl[6]  = '{1, 1, 15'h0000, 8'hFF, 32'h00001234, 1, 1, 32'h1111AAAA};
    tbl[7]  = '{1, 1, 15'h4000, 8'hFF, 32'h0000ABCD, 1, 0, 32'h0};
    tbl[8]  = '{1, 0, 15'h0000, 8'h00, 32'h0,        1, 0, 32'h0};
    tbl[9]  = '{1, 0, 15'h4000, 8'h00, 32'h0,        1, 1, 32'h00001234};
    tbl[10] = '{0, 0, 15'h0000, 8'h00, 32'h0,        1, 1, 32'h0000ABCD};

    for (int i = 0; i < 2; i++) begin touch[i] = 0; waking[i] = 0; wake_done[i] = 0; end
    pend_rv = 0; pend_known = 0; pend_rd = '0;
    reset = 1'b1;
    drive(0, 0, 15'h0, 8'h0, 32'h0);
    c2_valid = 0; c2_write = 0; c2_addr = '0; c2_mask = '0; c2_data = '0;

    step();
    step();
    check_model("reset");
    reset = 1'b0;

    // Directed vectors; row 7 hits bank 1 on the exact cycle its idle count reaches the limit.
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].m, tbl[i].d);
      step();
      chk($sformatf("tbl%0d_ready", i), 32'(obs_ready), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(obs_rv), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_bank_active", i), 32'(obs_act), 32'h3);
      if (tbl[i].ev) chk($sformatf("tbl%0d_rd_data", i), obs_rd, tbl[i].ed);
    end

    // Bank 1 only: bank 0 must fall asleep, then a held read wakes it.
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 15'h4000, 8'h0, 32'h0);
      step();
      check_model("bank1_only");
    end
    chk("bank0_asleep", 32'(obs_act[0]), 32'h0);
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 0, 15'h0005, 8'h0, 32'h0);
      step();
      check_model("wake");
      if (obs_ready) break;
      lowcnt++;
    end
    chk("wake_ready_low_cycles", 32'(lowcnt), 32'd4);
    drive(0, 0, 15'h0, 8'h0, 32'h0);
    step();
    check_model("wake_read");
    chk("wake_read_data", obs_rd, 32'hDEADBEEF);

    // Reset while bank 0 is waking.
    for (int i = 0; i < 12; i++) begin
      step();
      check_model("idle");
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 15'h0010, 8'h0, 32'h0);
      step();
      check_model("pre_reset");
    end
    drive(0, 0, 15'h0, 8'h0, 32'h0);
    reset = 1'b1;
    step();
    check_model("mid_wake_reset");
    reset = 1'b0;
    step();
    check_model("post_reset");
    chk("post_reset_active", 32'(obs_act), 32'h3);
    chk("post_reset_rd_valid", 32'(obs_rv), 32'h0);
    drive(1, 0, 15'h0010, 8'h0, 32'h0);
    step();
    drive(0, 0, 15'h0, 8'h0, 32'h0);
    step();
    chk("persist_rd_valid", 32'(obs_rv), 32'h1);
    chk("persist_rd_data", obs_rd, 32'h1111AAAA);

    // Random traffic with held commands and idle gaps long enough to reach standby.
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hold) begin
        if ((i % 64) < 40 && $urandom_range(0, 1) == 1) begin
          a = {1'($urandom_range(0, 1)), 11'd0, 3'($urandom_range(0, 7))};
          if ($urandom_range(0, 1) == 1)
            drive(1, 1, a, mem_m.exists(int'(a)) ? 8'($urandom) : 8'hFF, $urandom);
          else
            drive(1, 0, a, 8'h0, 32'h0);
        end else begin
          drive(0, 0, 15'($urandom), 8'h0, 32'h0);
        end
      end
      step();
      check_model("rand");
      hold = cmd_valid && !exp_ready;
    end
    drive(0, 0, 15'h0, 8'h0, 32'h0);

    // 16-bit single-bank instance with standby disabled.
    c2_valid = 1; c2_write = 1; c2_addr = 14'h0010; c2_mask = 4'hF; c2_data = 16'h1111;
    @(negedge clk);
    chk("d16_ready", 32'(c2_ready), 32'h1);
    @(posedge clk); #1;
    c2_data = 16'hAAAA; c2_mask = 4'h3;
    @(posedge clk); #1;
    c2_write = 0; c2_mask = 4'h0;
    @(posedge clk); #1;
    c2_valid = 0;
    @(negedge clk);
    chk("d16_rd_valid", 32'(c2_rv), 32'h1);
    chk("d16_masked_data", 32'(c2_rd), 32'h11AA);
    @(posedge clk); #1;
    @(negedge clk);
    chk("d16_rd_valid_pulse", 32'(c2_rv), 32'h0);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!c2_ready || !c2_act[0]) bad++;
    end
    chk("d16_no_standby", 32'(bad), 32'h0);
    @(posedge clk); #1;
    c2_valid = 1; c2_write = 0; c2_addr = 14'h0010;
    @(posedge clk); #1;
    c2_valid = 0;
    @(negedge clk);
    chk("d16_late_read", 32'(c2_rd), 32'h11AA);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule

// File: doc/spram_bank_ctrl.md
# spram_bank_ctrl

Parametrised iCE40UP single-port RAM controller built from SB_SPRAM256KA primitives. It gangs primitives in width (16/32-bit words) and stacks them in depth (1 or 2 banks), honours a per-nibble write mask, and returns read data over a valid/ready command plus rd_valid response protocol. Each bank enters STANDBY after a programmable idle period and wakes automatically on access. It sits between the HUB75E frame writer / scan reader and the SPRAM, replacing the fixed 32-bit always-on RAM wrapper.

## Interface
- DATA_WIDTH, 32, word width; 16 or 32 only (1 or 2 primitives per bank).
- BANKS, 2, depth stacking; 1 or 2 (BANKS*DATA_WIDTH/16 <= 4 primitives).
- IDLE_LIMIT, 1024, idle cycles before a bank enters STANDBY; 0 disables standby.
- WAKE_CYCLES, 3, cycles a bank spends in WAKING before accepting a command; >= 1.
- ADDR_WIDTH, derived, 14 + log2(BANKS); not overridable.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  word address; the MSB selects the bank when BANKS=2.
- cmd_mask  in  DATA_WIDTH/4  nibble write enables; bit i covers data[4i+3:4i].
- cmd_data  in  DATA_WIDTH  write data.
- rd_valid  out  1  one-cycle pulse; rd_data is valid in this cycle.
- rd_data  out  DATA_WIDTH  read data.
- bank_active  out  BANKS  1 = bank in ACTIVE state.

## Operation
- Primitives: CHIPSELECT=1, POWEROFF=1 (powered), SLEEP=0. STANDBY is driven from the bank FSM. Memory contents persist through STANDBY and reset; they are never cleared.
- Write: on accept, WREN=1 for the addressed bank only, with MASKWREN taken from the matching cmd_mask nibbles per primitive. Upper primitive holds data[31:16], lower holds data[15:0].
- Read: on accept, WREN=0 for the addressed bank. rd_valid is asserted the next cycle, and rd_data is muxed from the bank captured at accept. rd_data is defined only while rd_valid=1.
- Bank FSM states (one per bank):
  - ACTIVE:
    - STANDBY=0.
    - Idle counter increments each cycle the bank has no accepted command and saturates at IDLE_LIMIT.
    - Any accepted command to the bank clears the counter.
    - Counter == IDLE_LIMIT and IDLE_LIMIT != 0 -> STANDBY.
  - STANDBY:
    - STANDBY=1.
    - cmd_valid targeting this bank -> WAKING with wake counter = 0. STANDBY drops to 0 on the transition.
  - WAKING:
    - STANDBY=0; the wake counter increments.
    - Wake counter == WAKE_CYCLES-1 -> ACTIVE with idle counter cleared.
- cmd_ready = not reset AND the addressed bank is ACTIVE (combinational on cmd_addr).
- cmd_valid with cmd_ready=0 is held by the master; the controller neither drops nor reorders it.
- Banks are independent: a command to an ACTIVE bank is accepted while the other bank sleeps or wakes.
- cmd_mask = 0 on a write is a legal no-op write. It is accepted and clears the idle counter.

## Timing
- Reset values: cmd_ready=0 during reset, rd_valid=0, bank_active=all 1, every bank ACTIVE with idle counter 0, wake counters 0, and all STANDBY pins 0.
- Reset asserted mid-WAKING or in STANDBY: the bank is ACTIVE on the first cycle after reset deasserts.
- Throughput: one command per cycle per controller when the target bank is ACTIVE. Back-to-back reads give back-to-back rd_valid pulses.
- Read latency: accept at cycle N -> rd_valid and rd_data at N+1.
- Write then read of the same address in consecutive cycles returns the new data.
- Wake latency: cmd_valid first seen in STANDBY at cycle N -> WAKING during N+1..N+WAKE_CYCLES -> cmd_ready=1 at N+WAKE_CYCLES+1.
- Idle timing: last accept at cycle N -> STANDBY asserted from N+IDLE_LIMIT+1.
  - An accept in the same cycle the counter reaches IDLE_LIMIT wins: the bank stays ACTIVE and the counter clears.
- Idle counter width is clog2(IDLE_LIMIT+1) and saturates; it never wraps.

## Test plan
- Reset, then write 0xDEADBEEF to address 0x0005 with mask 0xFF, then read 0x0005 -> rd_valid one cycle after accept, rd_data=0xDEADBEEF.
- Write 0x11111111 to 0x0010, then write 0xAAAAAAAA with mask 0x0F, then read -> 0x1111AAAA. Repeat with DATA_WIDTH=16 and mask 0x3 -> lower byte only changes.
- BANKS=2: write 0x1234 to 0x0000 and 0xABCD to 0x4000, then read both back-to-back -> two consecutive rd_valid pulses carrying 0x1234 then 0xABCD, with no aliasing between banks.
- IDLE_LIMIT=8, WAKE_CYCLES=3: access bank 1 only for 20 cycles.
  - Bank 0 shows STANDBY=1 from idle cycle 9 and bank_active[0]=0.
  - A read to bank 0 sees cmd_ready low for exactly 4 cycles, then returns the pre-standby data.
- Assert reset for one cycle while bank 0 is WAKING -> bank_active=all 1 after reset, rd_valid=0, and previously written data still readable.
- IDLE_LIMIT=0: hold idle for 10000 cycles -> STANDBY never asserted and cmd_ready stays 1.
